data_memory_lsu: RTL

Parametrised, byte-addressed data memory with a load/store front end for the single-cycle and pipelined cores. It accepts one request at a time over a valid/ready handshake and supports byte, half and word (and dword at W=64) accesses with byte-lane writes and sign/zero extension. A programmable wait-state count models slower memories. Responses return over a second valid/ready handshake with an error flag.

---
 rtl/data_memory_lsu.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with a valid/ready load/store front end, wait states and sign/zero extension.
// Optional macro DM_MISALIGN_TRAP_EN: misaligned accesses fault instead of being aligned down.
module data_memory_lsu #(
   parameter int W     = 32,
   parameter int DEPTH = 8192,
   parameter int LAT   = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [1:0]   req_size,
   input  logic         req_unsigned,
   input  logic [W-1:0] req_addr,
   input  logic [W-1:0] req_wdata,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_rdata,
   output logic         rsp_err,
   output logic         busy
);

   localparam int NB   = W / 8;
   localparam int OFFS = $clog2(NB);
   localparam int IDXW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     cnt_q, cnt_d;
   logic           we_q;
   logic [1:0]     size_q;
   logic           uns_q;
   logic [W-1:0]   addr_q;
   logic [W-1:0]   wdata_q;
   logic           err_q;

   logic           accept;
   logic           commit;
   logic           wr_en;

   logic           cur_we;
   logic [1:0]     cur_size;
   logic           cur_uns;
   logic [W-1:0]   cur_addr;
   logic [W-1:0]   cur_wdata;

   logic [W-1:0]   low_mask;
   logic [W-1:0]   addr_al;
   logic           misalign;
   logic           out_of_range;
   logic           bad_size;
   logic           fault;
   logic [IDXW-1:0] idx;
   logic [OFFS-1:0] off;
   logic [3:0]     nbytes;
   logic [NB-1:0]  size_mask;
   logic [NB-1:0]  be;
   logic [W-1:0]   wlane;

   logic [W-1:0]   rd_word;
   logic [W-1:0]   shifted;
   logic           sign_bit;
   logic [W-1:0]   ext;

   assign req_ready = (state_q == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign busy      = (state_q != IDLE);

   // At LAT=0 the commit happens on the accept edge, before the capture registers load,
   // so the live request fields are used while still in IDLE.
   always_comb begin
      if (state_q == IDLE) begin
         cur_we    = req_we;
         cur_size  = req_size;
         cur_uns   = req_unsigned;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
      end else begin
         cur_we    = we_q;
         cur_size  = size_q;
         cur_uns   = uns_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
      end
   end

   always_comb begin
      case (cur_size)
         2'b00:   low_mask = '0;
         2'b01:   low_mask = W'(1);
         2'b10:   low_mask = W'(3);
         default: low_mask = W'(7);
      endcase
   end

   assign misalign     = |(cur_addr & low_mask);
   assign addr_al      = cur_addr & ~low_mask;
   assign out_of_range = |(addr_al >> (OFFS + IDXW));
   assign bad_size     = (W == 32) && (cur_size == 2'b11);

`ifdef DM_MISALIGN_TRAP_EN
   assign fault = out_of_range || bad_size || misalign;
`else
   assign fault = out_of_range || bad_size;
`endif

   assign idx    = addr_al[OFFS+IDXW-1:OFFS];
   assign off    = addr_al[OFFS-1:0];
   assign nbytes = 4'd1 << cur_size;

   always_comb begin
      size_mask = '0;
      for (int b = 0; b < NB; b++) begin
         size_mask[b] = (b < int'(nbytes));
      end
   end

   assign be    = size_mask << off;
   assign wlane = cur_wdata << {off, 3'b000};

   assign commit = ((state_q == IDLE) && accept && (LAT == 0)) ||
                   ((state_q == WAIT) && (cnt_q == 3'd0));
   assign wr_en  = commit && cur_we && !fault;

   // One narrow RAM per byte lane keeps lane enables trivially mappable to block RAM.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         logic [7:0] mem_lane [DEPTH];
         logic [7:0] rd_lane_q;

         always_ff @(posedge clk) begin
            if (wr_en && be[gi]) begin
               mem_lane[idx] <= wlane[8*gi +: 8];
            end
            if (commit) begin
               rd_lane_q <= mem_lane[idx];
            end
         end

         assign rd_word[8*gi +: 8] = rd_lane_q;
      end
   endgenerate

   assign shifted = rd_word >> {off, 3'b000};

   always_comb begin
      sign_bit = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if (b == int'(nbytes) - 1) begin
            sign_bit = shifted[8*b + 7];
         end
      end
   end

   always_comb begin
      ext = '0;
      for (int b = 0; b < NB; b++) begin
         if (b < int'(nbytes)) begin
            ext[8*b +: 8] = shifted[8*b +: 8];
         end else begin
            ext[8*b +: 8] = (cur_uns) ? 8'h00 : {8{sign_bit}};
         end
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = (state_q == RESP) && err_q;
   assign rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? ext : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (LAT == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 3'(LAT - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (commit) begin
            err_q <= fault;
         end
      end
   end

endmodule
